// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 14x14 multiply/accumulate datapath.
package binary_mul_pkg;
    localparam int OPND_W = 14;
    localparam int PROD_W = 28;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;
endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags when the true sum needs an extra bit.
module sat_add #(
    parameter int W = 36
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end
endmodule

// File: rtl/binary_mac_acc_14.sv
// Frame accumulator for 28-bit products: sums beats until p_last or MAX_LEN, then publishes
// the saturated sum, beat count and status with a one-cycle acc_valid pulse.
module binary_mac_acc_14
    import binary_mul_pkg::*;
#(
    parameter  int ACC_W   = 36,
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [PROD_W-1:0] p_in,
    input  logic              p_valid,
    input  logic              p_last,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow,
    output logic              len_err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic [CNT_W-1:0]   count_out_q, count_out_d;
    logic               overflow_q, overflow_d;
    logic               len_err_q, len_err_d;
    logic               acc_valid_q, acc_valid_d;

    // A beat arriving in IDLE starts from an empty frame, so the running state is masked off.
    logic               open;
    logic [ACC_W-1:0]   base_acc;
    logic [ACC_W-1:0]   sum;
    logic               sum_ovf;
    logic [CNT_W-1:0]   new_cnt;
    logic               new_ovf;

    assign open     = (state_q == ACC);
    assign base_acc = open ? acc_q : '0;
    assign new_cnt  = (open ? cnt_q : '0) + 1'b1;
    assign new_ovf  = (open & ovf_q) | sum_ovf;

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (base_acc),
        .b   (ACC_W'(p_in)),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        len_err_d   = len_err_q;
        acc_valid_d = acc_valid_q;
        if (en) begin
            acc_valid_d = 1'b0;
            if (p_valid) begin
                if (p_last || (new_cnt == MAX_CNT)) begin
                    acc_out_d   = sum;
                    count_out_d = new_cnt;
                    overflow_d  = new_ovf;
                    len_err_d   = ~p_last;
                    acc_valid_d = 1'b1;
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    state_d = ACC;
                    acc_d   = sum;
                    cnt_d   = new_cnt;
                    ovf_d   = new_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
            len_err_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
            len_err_q   <= len_err_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign count_out = count_out_q;
    assign overflow  = overflow_q;
    assign len_err   = len_err_q;
    assign acc_valid = acc_valid_q;
endmodule
